// File: rtl/breathe_pkg.sv
`default_nettype none
// ============================================================================
// breathe_pkg : phase encoding and width helpers for the breathing-LED sequencer
// Rev 1.0
// ============================================================================
package breathe_pkg;

  localparam int STATE_W = 3;
  localparam int CYC_W   = 8;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_RAMP_UP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_HOLD_HIGH = 3'd2;
  localparam logic [STATE_W-1:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD_LOW  = 3'd4;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int duty_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed for a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/breathe_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// breathe_seq_ctrl_if : command and status bundle of the breathing-LED sequencer
// Rev 1.0
// ============================================================================
interface breathe_seq_ctrl_if #(
  parameter int DUTY_W = 10
);

  logic                          start;
  logic                          stop;
  logic [7:0]                    cycles;
  logic                          busy;
  logic                          done;
  logic [breathe_pkg::STATE_W-1:0] state;
  logic [DUTY_W-1:0]             duty;
  logic                          led;

  modport master (
    output start, stop, cycles,
    input  busy, done, state, duty, led
  );

  modport slave (
    input  start, stop, cycles,
    output busy, done, state, duty, led
  );

endinterface
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// ============================================================================
// led_pwm_timebase : prescaler and PWM step counter, held at zero while not running
// Rev 1.0
// ============================================================================
module led_pwm_timebase
  import breathe_pkg::*;
#(
  parameter int CLK_PER_TICK = 100,
  parameter int PWM_STEPS    = 1000
) (
  input  wire                                 sys_clk,
  input  wire                                 sys_rst_n,
  input  wire                                 run,
  output logic                                tick,
  output logic [cnt_width(PWM_STEPS)-1:0]     pwm_cnt,
  output logic                                period_end
);

  localparam int PRE_W = cnt_width(CLK_PER_TICK);
  localparam int CNT_W = cnt_width(PWM_STEPS);

  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PWM_STEPS - 1);
  localparam logic [PRE_W-1:0] c_pre_one  = PRE_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_tick;
  logic             w_wrap;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    w_tick = run && (pre_q == c_pre_last);
    w_wrap = w_tick && (cnt_q == c_cnt_last);
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    if (!run) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (w_tick) begin
      pre_d = '0;
      cnt_d = w_wrap ? '0 : cnt_q + c_cnt_one;
    end else begin
      pre_d = pre_q + c_pre_one;
    end
  end

  always_comb begin
    tick       = w_tick;
    period_end = w_wrap;
    pwm_cnt    = cnt_q;
  end

endmodule
`default_nettype wire

// File: rtl/breathe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// breathe_seq_ctrl : breathe-cycle sequencer (ramp up, hold, ramp down, hold) driving the LED PWM
// Rev 1.0
// ============================================================================
module breathe_seq_ctrl
  import breathe_pkg::*;
#(
  parameter int CLK_PER_TICK = 100,
  parameter int PWM_STEPS    = 1000,
  parameter int HOLD_PERIODS = 250
) (
  input  wire               sys_clk,
  input  wire               sys_rst_n,
  breathe_seq_ctrl_if.slave ctl
);

  localparam int DUTY_W = duty_width(PWM_STEPS);
  localparam int HOLD_W = cnt_width(HOLD_PERIODS);
  localparam int CNT_W  = cnt_width(PWM_STEPS);

  localparam logic [DUTY_W-1:0] c_duty_max  = DUTY_W'(PWM_STEPS);
  localparam logic [DUTY_W-1:0] c_duty_top  = DUTY_W'(PWM_STEPS - 1);
  localparam logic [DUTY_W-1:0] c_duty_one  = DUTY_W'(1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_PERIODS - 1);
  localparam logic [HOLD_W-1:0] c_hold_one  = HOLD_W'(1);
  localparam logic [CYC_W-1:0]  c_cyc_sat   = '1;
  localparam logic [CYC_W-1:0]  c_cyc_one   = CYC_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CYC_W-1:0]   ncyc_q, ncyc_d;
  logic               done_q, done_d;
  logic               led_q, led_d;

  logic               w_busy;
  logic               w_run;
  logic               w_tick;
  logic               w_period_end;
  logic               w_adv;
  logic [CNT_W-1:0]   w_pwm_cnt;
  logic [CYC_W-1:0]   w_cyc_inc;

  // A stop clears the timebase on the same edge that returns the FSM to IDLE.
  assign w_busy = (state_q != ST_IDLE);
  assign w_run  = w_busy && !ctl.stop;

  led_pwm_timebase #(
    .CLK_PER_TICK (CLK_PER_TICK),
    .PWM_STEPS    (PWM_STEPS)
  ) u_timebase (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .run        (w_run),
    .tick       (w_tick),
    .pwm_cnt    (w_pwm_cnt),
    .period_end (w_period_end)
  );

  assign w_adv     = w_tick && w_period_end;
  assign w_cyc_inc = (cyc_q == c_cyc_sat) ? cyc_q : cyc_q + c_cyc_one;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      cyc_q   <= '0;
      ncyc_q  <= '0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      ncyc_q  <= ncyc_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    ncyc_d  = ncyc_q;
    done_d  = 1'b0;
    led_d   = w_run && ({{(DUTY_W - CNT_W){1'b0}}, w_pwm_cnt} < duty_q);
    if (ctl.stop) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctl.start) begin
            state_d = ST_RAMP_UP;
            ncyc_d  = ctl.cycles;
            cyc_d   = '0;
            duty_d  = '0;
          end
        end
        ST_RAMP_UP: begin
          if (w_adv) begin
            duty_d = duty_q + c_duty_one;
            if (duty_q == c_duty_top) begin
              duty_d  = c_duty_max;
              state_d = ST_HOLD_HIGH;
              hold_d  = '0;
            end
          end
        end
        ST_HOLD_HIGH: begin
          if (w_adv) begin
            if (hold_q == c_hold_last) begin
              state_d = ST_RAMP_DOWN;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + c_hold_one;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (w_adv) begin
            duty_d = duty_q - c_duty_one;
            if (duty_q == c_duty_one) begin
              state_d = ST_HOLD_LOW;
              hold_d  = '0;
            end
          end
        end
        ST_HOLD_LOW: begin
          if (w_adv) begin
            if (hold_q == c_hold_last) begin
              hold_d = '0;
              cyc_d  = w_cyc_inc;
              // cycles==0 runs forever: the saturated count can never match zero.
              if ((ncyc_q != '0) && (w_cyc_inc == ncyc_q)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_RAMP_UP;
              end
            end else begin
              hold_d = hold_q + c_hold_one;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctl.busy  = w_busy;
    ctl.done  = done_q;
    ctl.state = state_q;
    ctl.duty  = duty_q;
    ctl.led   = led_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_breathe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_breathe_seq_ctrl : directed bench with a closed-form phase model of the breathe sequence
// Rev 1.0
// ============================================================================
module tb_breathe_seq_ctrl;

  localparam int CPT  = 2;
  localparam int S    = 4;
  localparam int H    = 1;
  localparam int PER  = CPT * S;
  localparam int CYCP = 2 * S + 2 * H;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   e = 0;

  breathe_seq_ctrl_if #(.DUTY_W(3)) bus ();

  breathe_seq_ctrl #(
    .CLK_PER_TICK (CPT),
    .PWM_STEPS    (S),
    .HOLD_PERIODS (H)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .ctl       (bus)
  );

  always #5 clk = ~clk;

  // Phase position is derived purely from clocks elapsed since the accepting edge.
  function automatic int m_duty(input int t);
    int q;
    q = (t / PER) % CYCP;
    if (q < S) return q;
    if (q < S + H) return S;
    if (q < 2 * S + H) return S - (q - S - H);
    return 0;
  endfunction

  function automatic int m_state(input int t);
    int q;
    q = (t / PER) % CYCP;
    if (q < S) return 1;
    if (q < S + H) return 2;
    if (q < 2 * S + H) return 3;
    return 4;
  endfunction

  function automatic int m_pwm(input int t);
    return (t % PER) / CPT;
  endfunction

  function automatic logic [8:0] outs();
    return {bus.busy, bus.done, bus.state, bus.duty, bus.led};
  endfunction

  logic m_run  = 1'b0;
  logic m_done = 1'b0;
  logic m_led  = 1'b0;
  int   m_t    = 0;
  int   m_n    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_led  <= 1'b0;
      m_t    <= 0;
      m_n    <= 0;
    end else if (m_run) begin
      if (bus.stop) begin
        m_run  <= 1'b0;
        m_done <= 1'b0;
        m_led  <= 1'b0;
      end else begin
        m_led <= (m_pwm(m_t) < m_duty(m_t));
        m_t   <= m_t + 1;
        if (m_n != 0 && m_t + 1 == m_n * CYCP * PER) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else begin
      m_done <= 1'b0;
      m_led  <= 1'b0;
      if (bus.start && !bus.stop) begin
        m_run <= 1'b1;
        m_t   <= 0;
        m_n   <= int'(bus.cycles);
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] exp_v;
    if (rst_n) begin
      exp_v = {m_run, m_done,
               m_run ? 3'(m_state(m_t)) : 3'd0,
               m_run ? 3'(m_duty(m_t)) : 3'd0,
               m_led};
      checks = checks + 1;
      if (outs() !== exp_v) begin
        errors = errors + 1;
        $display("FAIL model t=%0t {busy,done,state,duty,led} got=%b_%b_%0d_%0d_%b exp=%b_%b_%0d_%0d_%b",
                 $time, bus.busy, bus.done, bus.state, bus.duty, bus.led,
                 exp_v[8], exp_v[7], exp_v[6:4], exp_v[3:1], exp_v[0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    e = e + 1;
  endtask

  task automatic run_to(input int target);
    while (e < target) step();
  endtask

  // Leaves e=0 at the negedge following the edge that accepted start.
  task automatic start_run(input logic [7:0] n);
    bus.cycles = n;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    e = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int led_hi;
    int hh_hi;
    int nd;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.cycles = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'(outs()), 0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_after_reset", int'(outs()), 0);

    // Asynchronous reset in the middle of RAMP_UP
    start_run(8'd3);
    run_to(12);
    chk("pre_reset_state", int'(bus.state), 1);
    chk("pre_reset_duty", int'(bus.duty), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", int'(outs()), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_until_start", int'(outs()), 0);

    // Two-cycle run with duty/phase milestones and led duty measurement
    led_hi = 0;
    hh_hi  = 0;
    start_run(8'd2);
    chk("start_state", int'(bus.state), 1);
    chk("start_duty", int'(bus.duty), 0);
    while (e < 162) begin
      step();
      if (e >= 17 && e <= 24) led_hi = led_hi + int'(bus.led);
      if (e >= 33 && e <= 40) hh_hi = hh_hi + int'(bus.led);
      case (e)
        8:   chk("duty@8", int'(bus.duty), 1);
        16:  chk("duty@16", int'(bus.duty), 2);
        24:  chk("duty@24", int'(bus.duty), 3);
        32: begin
          chk("duty@32", int'(bus.duty), 4);
          chk("state@32", int'(bus.state), 2);
        end
        40:  chk("state@40", int'(bus.state), 3);
        72:  chk("state@72", int'(bus.state), 4);
        80:  chk("state@80", int'(bus.state), 1);
        159: chk("busy_done@159", int'({bus.busy, bus.done}), 2);
        160: chk("busy_done@160", int'({bus.busy, bus.done}), 1);
        161: chk("done_cleared@161", int'(bus.done), 0);
        default: ;
      endcase
    end
    chk("led_high_at_duty2", led_hi, 4);
    chk("led_high_in_hold_high", hh_hi, 8);

    // Stop with simultaneous start during RAMP_DOWN
    start_run(8'd2);
    run_to(50);
    chk("stop_pre_state", int'(bus.state), 3);
    bus.stop   = 1'b1;
    bus.start  = 1'b1;
    bus.cycles = 8'd5;
    step();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk("stop_outs@51", int'(outs()), 0);
    nd = 0;
    repeat (120) begin
      step();
      nd = nd + int'(bus.done);
    end
    chk("no_done_after_stop", nd, 0);
    start_run(8'd1);
    chk("restart_duty", int'(bus.duty), 0);
    run_to(8);
    chk("restart_duty@8", int'(bus.duty), 1);
    run_to(80);
    chk("single_cycle_done@80", int'(bus.done), 1);

    // cycles=0 runs until stopped
    step();
    start_run(8'd0);
    nd = 0;
    while (e < 800) begin
      step();
      nd = nd + int'(bus.done);
    end
    chk("forever_busy@800", int'(bus.busy), 1);
    chk("forever_state@800", int'(bus.state), 1);
    chk("forever_no_done", nd, 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("forever_stop_outs", int'(outs()), 0);

    // start while busy must not restart or resample cycles
    step();
    start_run(8'd2);
    run_to(19);
    bus.start  = 1'b1;
    bus.cycles = 8'd7;
    step();
    bus.start  = 1'b0;
    bus.cycles = 8'd0;
    run_to(159);
    chk("ignored_start_busy@159", int'({bus.busy, bus.done}), 2);
    step();
    chk("ignored_start_done@160", int'({bus.busy, bus.done}), 1);
    step();
    chk("ignored_start_idle@161", int'(outs()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/breathe_seq_ctrl.md
Name: breathe_seq_ctrl

Overview:
Sequencer for the breathing-LED function: accepts start/stop commands and runs a programmable number of breathe cycles, each made of four phases: RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW. It owns the PWM timebase and the duty register, drives the LED pin directly, and reports busy/done/state to the board-level key or command logic.

Parameters:
CLK_PER_TICK, 100, sys_clk cycles per PWM step (2 us at 50 MHz); must be >= 2.
PWM_STEPS, 1000, PWM steps per PWM period; also the maximum duty value.
HOLD_PERIODS, 250, PWM periods spent in each HOLD phase; must be >= 1.

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle start request; honoured only in IDLE.
stop  in  1  single-cycle abort request; honoured in any state.
cycles  in  8  number of breathe cycles to run; sampled on accepted start; 0 means run forever.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse when the programmed cycle count completes.
state  out  3  current phase: 0 IDLE, 1 RAMP_UP, 2 HOLD_HIGH, 3 RAMP_DOWN, 4 HOLD_LOW.
duty  out  clog2(PWM_STEPS+1)  current duty value, 0..PWM_STEPS.
led  out  1  PWM output; high is LED on.

Behaviour:
- Reset (async, sys_rst_n low): state=IDLE, duty=0, led=0, done=0, busy=0, cycle counter=0, hold counter=0, timebase cleared.
- Timebase:
  - Prescaler runs 0..CLK_PER_TICK-1.
  - tick = busy && prescaler==CLK_PER_TICK-1.
  - pwm_cnt runs 0..PWM_STEPS-1 and advances on tick.
  - period_end = tick && pwm_cnt==PWM_STEPS-1.
  - In IDLE, prescaler and pwm_cnt are held at 0. Counting starts the cycle after start is accepted.
- IDLE:
  - start && !stop -> RAMP_UP.
  - Latch cycles; clear the cycle counter; duty=0.
- RAMP_UP:
  - On each period_end, duty+1.
  - At period_end with duty==PWM_STEPS-1: duty becomes PWM_STEPS, state -> HOLD_HIGH, hold counter=0.
- HOLD_HIGH:
  - duty is held.
  - Hold counter increments on each period_end.
  - At the period_end where hold counter==HOLD_PERIODS-1 -> RAMP_DOWN.
- RAMP_DOWN:
  - On each period_end, duty-1.
  - At period_end with duty==1: duty becomes 0, state -> HOLD_LOW, hold counter=0.
- HOLD_LOW:
  - Counts HOLD_PERIODS period_ends, as in HOLD_HIGH.
  - On the final one, the cycle counter increments.
  - If latched cycles!=0 and the new count equals cycles: state -> IDLE, done=1 for exactly one cycle.
  - Otherwise -> RAMP_UP.
  - For cycles==0, the cycle counter saturates at 255 and never terminates the run.
- Cycle length: 2*PWM_STEPS + 2*HOLD_PERIODS PWM periods; PWM period = CLK_PER_TICK*PWM_STEPS clocks.
- led is registered: led <= busy && (pwm_cnt < duty), which gives one clock of latency relative to pwm_cnt.
  - duty=0 gives constant 0.
  - duty=PWM_STEPS gives constant 1.
- stop: takes priority over everything, including a simultaneous start or a simultaneous final period_end.
  - Next edge: state=IDLE, duty=0, led=0, timebase cleared.
  - done is not asserted.
- start while busy: ignored; cycles is not re-sampled.
- duty only ever changes on period_end, so no partial PWM period is emitted with a mixed duty.

Decomposition:
- Package breathe_pkg: state encoding constants (IDLE..HOLD_LOW), the state width, and a function for the duty/counter width (clog2).
- Sub-module led_pwm_timebase:
  - Holds the prescaler and pwm_cnt.
  - Inputs: sys_clk, sys_rst_n, run.
  - Outputs: tick, pwm_cnt, period_end.
  - Parameterised by CLK_PER_TICK and PWM_STEPS.
- The top level holds the FSM, duty, hold/cycle counters and the led compare.

Test Plan:
All tests use CLK_PER_TICK=2, PWM_STEPS=4, HOLD_PERIODS=1, giving a PWM period of 8 clocks and a breathe cycle of 80 clocks. Edge 0 is the edge that accepts start.
1. Reset mid-run: assert sys_rst_n low asynchronously during RAMP_UP -> all outputs are 0 immediately, without waiting for a clock; after release the block stays in IDLE until start.
2. start, cycles=2 -> duty steps 1,2,3,4 at edges 8,16,24,32; state HOLD_HIGH at 32, RAMP_DOWN at 40, HOLD_LOW at 72, RAMP_UP at 80; done pulses one cycle from edge 160; busy falls at 160.
3. led duty check in cycles=2 run: while duty=2 (edges 16..24), led is high exactly 4 of 8 clocks; in HOLD_HIGH (edges 32..40), led is constantly 1.
4. stop at edge 50 (RAMP_DOWN), with start also high -> state=IDLE, duty=0, led=0 from edge 51; no done pulse; a later start restarts from duty 0.
5. cycles=0 -> still busy at edge 800 (10 cycles) with no done; stop then returns to IDLE.
6. start pulsed at edge 20 while busy, with a different cycles value -> ignored; the original count still completes at edge 160.
